rank_filter_3x3: RTL

//  Streaming 3x3 rank filter for the pixel pipeline: median, minimum (erosion), maximum (dilation) or bypass.

---
 rtl/rank_filter_pkg.sv | 34 +++
 rtl/rank_filter_3x3_sort3.sv | 48 ++++
 rtl/rank_filter_3x3.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rank_filter_pkg.sv
// Shared constants and the 3-way compare helper for the 3x3 rank filter.
package rank_filter_pkg;

    localparam logic [1:0] MODE_MEDIAN = 2'd0;
    localparam logic [1:0] MODE_MIN    = 2'd1;
    localparam logic [1:0] MODE_MAX    = 2'd2;
    localparam logic [1:0] MODE_BYPASS = 2'd3;

    // Fixed pipeline depth: input align, window shift, three sorter stages.
    localparam int LAT = 5;

    // Which of the three inputs (0=a, 1=b, 2=c) holds the max, mid and min.
    typedef struct packed {
        logic [1:0] max_idx;
        logic [1:0] mid_idx;
        logic [1:0] min_idx;
    } sort_sel_t;

    // Unsigned 3-way compare from the flags a>=b, b>=c, a>=c.
    // Ties are broken so that max and min never pick the same input,
    // which makes the mid index simply the remaining one.
    function automatic sort_sel_t sort3_select(input logic ab, input logic bc, input logic ac);
        sort_sel_t s;
        if (ab && ac)       s.max_idx = 2'd0;
        else if (!ab && bc) s.max_idx = 2'd1;
        else                s.max_idx = 2'd2;
        if (bc && ac)       s.min_idx = 2'd2;
        else if (ab && !bc) s.min_idx = 2'd1;
        else                s.min_idx = 2'd0;
        s.mid_idx = 2'd3 - s.max_idx - s.min_idx;
        return s;
    endfunction

endpackage

// File: rtl/rank_filter_3x3_sort3.sv
// Registered 3-input sorter: max/mid/min one clock after the inputs.
module rank_filter_3x3_sort3
    import rank_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] max_v,
    output logic [DATA_WIDTH-1:0] mid_v,
    output logic [DATA_WIDTH-1:0] min_v
);

    sort_sel_t sel;

    function automatic logic [DATA_WIDTH-1:0] pick(input logic [1:0] idx,
                                                   input logic [DATA_WIDTH-1:0] x0,
                                                   input logic [DATA_WIDTH-1:0] x1,
                                                   input logic [DATA_WIDTH-1:0] x2);
        case (idx)
            2'd0:    pick = x0;
            2'd1:    pick = x1;
            default: pick = x2;
        endcase
    endfunction

    // Compare all three pairs and derive the rank order.
    always_comb begin
        sel = sort3_select(a >= b, b >= c, a >= c);
    end

    // Register the sorted values.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            max_v <= '0;
            mid_v <= '0;
            min_v <= '0;
        end else begin
            max_v <= pick(sel.max_idx, a, b, c);
            mid_v <= pick(sel.mid_idx, a, b, c);
            min_v <= pick(sel.min_idx, a, b, c);
        end
    end

endmodule

// File: rtl/rank_filter_3x3.sv
// Streaming 3x3 rank filter (median / min / max / bypass) with its own line
// buffers. Sync signals {valid, hs, vs} travel through a LAT-deep delay line;
// borders and over-long line tails are forced to zero.
module rank_filter_3x3
    import rank_filter_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int IMG_WIDTH_MAX = 1920,
    parameter int ADDR_WIDTH    = 11
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    input  logic                  data_in_hs,
    input  logic                  data_in_vs,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  data_out_hs,
    output logic                  data_out_vs,
    output logic                  line_overflow
);

    // One extra counter bit so the column count can sit at IMG_WIDTH_MAX
    // even when IMG_WIDTH_MAX == 2**ADDR_WIDTH.
    localparam int               CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] COL_LIMIT = CNT_W'(IMG_WIDTH_MAX);

    logic [CNT_W-1:0]      col_cnt;
    logic [1:0]            row_cnt;   // saturates at 2: only rows 0, 1 and >=2 matter
    logic                  hs_q, vs_q, frame_armed;
    logic [1:0]            mode_q;
    logic                  vs_rise, armed_now, col_over, wr_en, inside_now;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [1:0]            mode_now;

    logic [DATA_WIDTH-1:0] buf0 [IMG_WIDTH_MAX];
    logic [DATA_WIDTH-1:0] buf1 [IMG_WIDTH_MAX];
    logic [DATA_WIDTH-1:0] tap1, tap2, pix_s1;

    logic [2:0]            ctrl_pipe   [LAT];   // {valid, hs, vs}
    logic                  inside_pipe [LAT];
    logic [1:0]            mode_pipe   [LAT];

    logic [DATA_WIDTH-1:0] win [3][3];          // [row: 0=r-2 .. 2=r][col: 0=newest]

    logic [DATA_WIDTH-1:0] row_max [3];
    logic [DATA_WIDTH-1:0] row_mid [3];
    logic [DATA_WIDTH-1:0] row_min [3];
    logic [DATA_WIDTH-1:0] max_max, max_mid, max_min;
    logic [DATA_WIDTH-1:0] mid_max, mid_mid, mid_min;
    logic [DATA_WIDTH-1:0] min_max, min_mid, min_min;
    logic [DATA_WIDTH-1:0] fin_max, med_v, fin_min;
    logic [DATA_WIDTH-1:0] min_min_q, max_max_q, centre_s3, centre_s4, centre_s5;
    logic [DATA_WIDTH-1:0] rank_sel;
    logic                  unused_ok;

    // Frame/line bookkeeping decoded from the raw input syncs.
    always_comb begin
        vs_rise    = data_in_vs && !vs_q;
        armed_now  = frame_armed || vs_rise;
        col_over   = col_cnt >= COL_LIMIT;
        wr_en      = data_in_valid && data_in_hs && !col_over;
        ram_addr   = col_over ? '0 : col_cnt[ADDR_WIDTH-1:0];
        mode_now   = vs_rise ? cfg_mode : mode_q;
        inside_now = armed_now && (row_cnt == 2'd2) && (col_cnt >= CNT_W'(2)) && !col_over;
    end

    // Column/row counters, mode capture, arming and the sticky overflow flag.
    // vs_q resets high so a frame already in progress at reset release is not
    // mistaken for a new frame start; the output waits for a genuine vs rise.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            col_cnt       <= '0;
            row_cnt       <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b1;
            frame_armed   <= 1'b0;
            mode_q        <= MODE_MEDIAN;
            line_overflow <= 1'b0;
        end else begin
            hs_q <= data_in_hs;
            vs_q <= data_in_vs;
            if (vs_rise) begin
                frame_armed <= 1'b1;
                mode_q      <= cfg_mode;
            end
            if (!data_in_hs)
                col_cnt <= '0;
            else if (data_in_valid && !col_over)
                col_cnt <= col_cnt + CNT_W'(1);
            if (!data_in_vs)
                row_cnt <= '0;
            else if (hs_q && !data_in_hs && (col_cnt != '0) && (row_cnt != 2'd2))
                row_cnt <= row_cnt + 2'd1;
            if (data_in_valid && data_in_hs && col_over)
                line_overflow <= 1'b1;
            else if (vs_rise)
                line_overflow <= 1'b0;
        end
    end

    // Line buffers, read-before-write: buf0 holds row r-1, buf1 row r-2.
    always_ff @(posedge clk) begin
        tap1 <= buf0[ram_addr];
        tap2 <= buf1[ram_addr];
        if (wr_en) begin
            buf0[ram_addr] <= data_in;
            buf1[ram_addr] <= buf0[ram_addr];
        end
    end

    // Stage-1 pixel align plus the sync/flag/mode delay lines.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pix_s1 <= '0;
            for (int i = 0; i < LAT; i++) begin
                ctrl_pipe[i]   <= '0;
                inside_pipe[i] <= 1'b0;
                mode_pipe[i]   <= MODE_MEDIAN;
            end
        end else begin
            pix_s1         <= data_in;
            ctrl_pipe[0]   <= {data_in_valid && armed_now, data_in_hs && armed_now,
                               data_in_vs && armed_now};
            inside_pipe[0] <= inside_now;
            mode_pipe[0]   <= mode_now;
            for (int i = 1; i < LAT; i++) begin
                ctrl_pipe[i]   <= ctrl_pipe[i-1];
                inside_pipe[i] <= inside_pipe[i-1];
                mode_pipe[i]   <= mode_pipe[i-1];
            end
        end
    end

    // 3x3 window: shifts on valid pixels, cleared outside active lines.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else if (!ctrl_pipe[0][1] || !ctrl_pipe[0][0]) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else if (ctrl_pipe[0][2]) begin
            for (int i = 0; i < 3; i++) begin
                win[i][2] <= win[i][1];
                win[i][1] <= win[i][0];
            end
            win[0][0] <= tap2;
            win[1][0] <= tap1;
            win[2][0] <= pix_s1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_row
        rank_filter_3x3_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_row (
            .clk(clk), .reset_p(reset_p),
            .a(win[i][0]), .b(win[i][1]), .c(win[i][2]),
            .max_v(row_max[i]), .mid_v(row_mid[i]), .min_v(row_min[i])
        );
    end

    rank_filter_3x3_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_col_max (
        .clk(clk), .reset_p(reset_p),
        .a(row_max[0]), .b(row_max[1]), .c(row_max[2]),
        .max_v(max_max), .mid_v(max_mid), .min_v(max_min)
    );
    rank_filter_3x3_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_col_mid (
        .clk(clk), .reset_p(reset_p),
        .a(row_mid[0]), .b(row_mid[1]), .c(row_mid[2]),
        .max_v(mid_max), .mid_v(mid_mid), .min_v(mid_min)
    );
    rank_filter_3x3_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_col_min (
        .clk(clk), .reset_p(reset_p),
        .a(row_min[0]), .b(row_min[1]), .c(row_min[2]),
        .max_v(min_max), .mid_v(min_mid), .min_v(min_min)
    );
    rank_filter_3x3_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_final (
        .clk(clk), .reset_p(reset_p),
        .a(max_min), .b(mid_mid), .c(min_max),
        .max_v(fin_max), .mid_v(med_v), .min_v(fin_min)
    );

    // Sorter outputs that no mode needs.
    assign unused_ok = ^{max_mid, mid_max, mid_min, min_mid, fin_max, fin_min};

    // Keep min, max and the raw centre aligned with the median stage.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            min_min_q <= '0;
            max_max_q <= '0;
            centre_s3 <= '0;
            centre_s4 <= '0;
            centre_s5 <= '0;
        end else begin
            min_min_q <= min_min;
            max_max_q <= max_max;
            centre_s3 <= win[1][1];
            centre_s4 <= centre_s3;
            centre_s5 <= centre_s4;
        end
    end

    // Mode select and border/invalid zeroing at the last stage.
    always_comb begin
        case (mode_pipe[LAT-1])
            MODE_MIN:    rank_sel = min_min_q;
            MODE_MAX:    rank_sel = max_max_q;
            MODE_BYPASS: rank_sel = centre_s5;
            default:     rank_sel = med_v;
        endcase
        data_out_valid = ctrl_pipe[LAT-1][2];
        data_out_hs    = ctrl_pipe[LAT-1][1];
        data_out_vs    = ctrl_pipe[LAT-1][0];
        data_out       = (data_out_valid && inside_pipe[LAT-1]) ? rank_sel : '0;
    end

endmodule
